// File: rtl/echo_delay_line.sv
// Echo delay line: captures changes of the live voice tuple and replays them as decaying
// echoes from a timestamped FIFO, one head-of-line entry examined per enabled cycle.
module echo_delay_line #(
  parameter int DEPTH    = 32,
  parameter int TW       = 24,
  parameter int MAX_TAPS = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [TW-1:0] delay,
  input  logic [1:0]    taps,
  input  logic [1:0]    decay,
  input  logic          note_on,
  input  logic [6:0]    note,
  input  logic [6:0]    vel,
  input  logic [8:0]    pb,
  input  logic [1:0]    cc1,
  input  logic [6:0]    cc1mod,
  output logic          echo_valid,
  output logic          echo_on,
  output logic [6:0]    echo_note,
  output logic [6:0]    echo_vel,
  output logic [8:0]    echo_pb,
  output logic [1:0]    echo_cc1,
  output logic [6:0]    echo_cc1mod,
  output logic [1:0]    echo_tap,
  output logic          full,
  output logic          overflow
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic       on;
    logic [6:0] note;
    logic [6:0] vel;
    logic [8:0] pb;
    logic [1:0] cc1;
    logic [6:0] cc1mod;
  } voice_t;

  typedef struct packed {
    voice_t        v;
    logic [1:0]    tap;
    logic [TW-1:0] due;
  } entry_t;

  localparam voice_t IDLE_VOICE = '{on: 1'b0, note: 7'd0, vel: 7'd0, pb: 9'h100,
                                   cc1: 2'd0, cc1mod: 7'd127};

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [TW-1:0] now;
  voice_t        last;

  voice_t        live;
  entry_t        head;
  entry_t        req_entry;
  entry_t        cap_entry;
  entry_t        ent_a;
  logic [TW-1:0] eff_delay;
  logic [TW-1:0] head_age;
  logic [1:0]    tap_lim;
  logic [6:0]    req_vel;
  logic          pop;
  logic          cap;
  logic          req_push;
  logic          cap_push;
  logic          push_a;
  logic          push_b;
  logic          acc_a;
  logic          acc_b;
  logic          drop;
  logic [AW:0]   cnt_pop;

  assign live      = '{on: note_on, note: note, vel: vel, pb: pb, cc1: cc1, cc1mod: cc1mod};
  assign eff_delay = (delay == '0) ? TW'(1) : delay;
  assign tap_lim   = (taps > 2'(MAX_TAPS)) ? 2'(MAX_TAPS) : taps;
  assign head      = mem[rd_ptr];

  // Serial-number comparison: the head is due once now has reached due within half the range.
  assign head_age  = now - head.due;
  assign pop       = en && (count != '0) && !head_age[TW-1];

  assign req_vel   = head.v.vel >> decay;
  assign req_push  = pop && (head.tap < tap_lim) && (!head.v.on || (req_vel != 7'd0));
  assign cap       = en && (live != last);
  assign cap_push  = cap && (tap_lim != 2'd0);

  always_comb begin
    req_entry       = head;
    req_entry.v.vel = req_vel;
    req_entry.tap   = head.tap + 2'd1;
    req_entry.due   = now + eff_delay;
    cap_entry       = '{v: live, tap: 2'd1, due: now + eff_delay};
    cap_entry.v.vel = vel >> 1;
  end

  // Requeued entry takes the first slot; the capture only gets the second when both push.
  assign ent_a   = req_push ? req_entry : cap_entry;
  assign push_a  = req_push || cap_push;
  assign push_b  = req_push && cap_push;
  assign cnt_pop = count - (AW+1)'(pop);
  assign acc_a   = push_a && (cnt_pop < (AW+1)'(DEPTH));
  assign acc_b   = push_b && ((cnt_pop + (AW+1)'(acc_a)) < (AW+1)'(DEPTH));
  assign drop    = (push_a && !acc_a) || (push_b && !acc_b);
  assign full    = (count == (AW+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (acc_a) mem[wr_ptr] <= ent_a;
    if (acc_b) mem[wr_ptr + AW'(1)] <= cap_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      now         <= '0;
      last        <= IDLE_VOICE;
      overflow    <= 1'b0;
      echo_valid  <= 1'b0;
      echo_tap    <= 2'd0;
      echo_on     <= 1'b0;
      echo_note   <= 7'd0;
      echo_vel    <= 7'd0;
      echo_pb     <= 9'h100;
      echo_cc1    <= 2'd0;
      echo_cc1mod <= 7'd127;
    end else if (en) begin
      now        <= now + TW'(1);
      rd_ptr     <= rd_ptr + AW'(pop);
      wr_ptr     <= wr_ptr + AW'(acc_a) + AW'(acc_b);
      count      <= cnt_pop + (AW+1)'(acc_a) + (AW+1)'(acc_b);
      echo_valid <= pop;
      if (cap)  last     <= live;
      if (drop) overflow <= 1'b1;
      if (pop) begin
        echo_tap    <= head.tap;
        echo_on     <= head.v.on;
        echo_note   <= head.v.note;
        echo_vel    <= head.v.vel;
        echo_pb     <= head.v.pb;
        echo_cc1    <= head.v.cc1;
        echo_cc1mod <= head.v.cc1mod;
      end
    end
  end

endmodule

// File: tb/tb_echo_delay_line.sv
// Scoreboard bench for echo_delay_line: expected echoes are queued when a capture is driven
// and compared, field by field and by enabled-cycle index, when echo_valid is seen.
module tb_echo_delay_line;
  localparam int DEPTH = 4, TW = 8, MAX_TAPS = 3;

  logic          clk = 1'b0;
  logic          reset, en;
  logic [TW-1:0] delay;
  logic [1:0]    taps, decay;
  logic          note_on;
  logic [6:0]    note, vel;
  logic [8:0]    pb;
  logic [1:0]    cc1;
  logic [6:0]    cc1mod;
  logic          echo_valid, echo_on;
  logic [6:0]    echo_note, echo_vel;
  logic [8:0]    echo_pb;
  logic [1:0]    echo_cc1;
  logic [6:0]    echo_cc1mod;
  logic [1:0]    echo_tap;
  logic          full, overflow;

  echo_delay_line #(.DEPTH(DEPTH), .TW(TW), .MAX_TAPS(MAX_TAPS)) dut (
    .clk(clk), .reset(reset), .en(en), .delay(delay), .taps(taps), .decay(decay),
    .note_on(note_on), .note(note), .vel(vel), .pb(pb), .cc1(cc1), .cc1mod(cc1mod),
    .echo_valid(echo_valid), .echo_on(echo_on), .echo_note(echo_note), .echo_vel(echo_vel),
    .echo_pb(echo_pb), .echo_cc1(echo_cc1), .echo_cc1mod(echo_cc1mod), .echo_tap(echo_tap),
    .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc; int on; int note; int vel; int pb; int cc1; int cc1mod; int tap;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic expect_echo(input int dt, input int tap, input int v);
    exp_t x;
    x.cyc = cyc + dt; x.on = int'(note_on); x.note = int'(note); x.vel = v;
    x.pb = int'(pb); x.cc1 = int'(cc1); x.cc1mod = int'(cc1mod); x.tap = tap;
    sb.push_back(x);
  endtask

  task automatic monitor();
    if (echo_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_echo", echo_valid, 0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        $display("echo cyc=%0d on=%0d note=%0d vel=%0d tap=%0d", cyc, echo_on, echo_note,
                 echo_vel, echo_tap);
        chk("echo_cycle", cyc, x.cyc);
        chk("echo_on", echo_on, x.on);
        chk("echo_note", echo_note, x.note);
        chk("echo_vel", echo_vel, x.vel);
        chk("echo_pb", echo_pb, x.pb);
        chk("echo_cc1", echo_cc1, x.cc1);
        chk("echo_cc1mod", echo_cc1mod, x.cc1mod);
        chk("echo_tap", echo_tap, x.tap);
      end
    end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
      chk("echo_valid_missing", echo_valid, 1);
      void'(sb.pop_front());
    end
  endtask

  task automatic step();
    logic e;
    e = en;
    @(posedge clk);
    #1;
    if (e) begin
      cyc++;
      monitor();
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic set_voice(input logic o, input int n, input int v, input int p,
                           input int c, input int m);
    note_on = o; note = 7'(n); vel = 7'(v); pb = 9'(p); cc1 = 2'(c); cc1mod = 7'(m);
  endtask

  // Returning to idle inputs is itself a capture, so it is done with echoes bypassed.
  task automatic go_idle();
    taps = 2'd0;
    set_voice(0, 0, 0, 'h100, 0, 127);
    step();
  endtask

  task automatic check_reset_state(input string pfx);
    chk({pfx, "_valid"}, echo_valid, 0);
    chk({pfx, "_on"}, echo_on, 0);
    chk({pfx, "_note"}, echo_note, 0);
    chk({pfx, "_vel"}, echo_vel, 0);
    chk({pfx, "_pb"}, echo_pb, 'h100);
    chk({pfx, "_cc1"}, echo_cc1, 0);
    chk({pfx, "_cc1mod"}, echo_cc1mod, 127);
    chk({pfx, "_tap"}, echo_tap, 0);
    chk({pfx, "_full"}, full, 0);
    chk({pfx, "_overflow"}, overflow, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; en = 1'b1; delay = 8'd10; taps = 2'd0; decay = 2'd0;
    set_voice(0, 0, 0, 'h100, 0, 127);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    cyc = 0;
    check_reset_state("rst");
    run(2);

    // Timestamp wrap: capture with now=250, echo at now=14.
    delay = 8'd20; taps = 2'd1;
    while (cyc < 250) step();
    set_voice(1, 70, 90, 'h1A5, 2, 33);
    step();
    expect_echo(20, 1, 45);
    run(25);
    go_idle();

    // Single tap, delay 10.
    delay = 8'd10; taps = 2'd1;
    set_voice(1, 60, 100, 'h100, 0, 127);
    step();
    expect_echo(10, 1, 50);
    run(30);
    go_idle();

    // Delay of zero behaves as one.
    delay = 8'd0; taps = 2'd1;
    set_voice(1, 50, 40, 'h0F0, 1, 5);
    step();
    expect_echo(1, 1, 20);
    run(5);
    go_idle();

    // Clock enable low freezes the schedule.
    delay = 8'd5; taps = 2'd1;
    set_voice(1, 52, 60, 'h100, 0, 127);
    step();
    expect_echo(5, 1, 30);
    en = 1'b0;
    run(7);
    en = 1'b1;
    run(10);
    go_idle();

    // Three taps with decay 1.
    delay = 8'd8; taps = 2'd3; decay = 2'd1;
    set_voice(1, 62, 100, 'h100, 0, 127);
    step();
    expect_echo(8, 1, 50);
    expect_echo(16, 2, 25);
    expect_echo(24, 3, 12);
    run(35);
    go_idle();

    // Decay 3: note-on third tap suppressed, note-off always repeats.
    delay = 8'd8; taps = 2'd3; decay = 2'd3;
    set_voice(1, 64, 16, 'h100, 0, 127);
    step();
    expect_echo(8, 1, 8);
    expect_echo(16, 2, 1);
    run(35);
    set_voice(0, 64, 16, 'h100, 0, 127);
    step();
    expect_echo(8, 1, 8);
    expect_echo(16, 2, 1);
    expect_echo(24, 3, 0);
    run(35);
    go_idle();

    // Requeue and capture on the same edge: requeued entry is ahead of the new capture.
    delay = 8'd8; taps = 2'd2; decay = 2'd0;
    set_voice(1, 30, 80, 'h100, 0, 127);
    step();
    expect_echo(8, 1, 40);
    expect_echo(16, 2, 40);
    run(7);
    set_voice(1, 31, 60, 'h100, 0, 127);
    step();
    expect_echo(9, 1, 30);
    expect_echo(17, 2, 30);
    run(25);
    go_idle();

    // Overflow with a four-entry queue.
    delay = 8'd100; taps = 2'd1; decay = 2'd0;
    for (int i = 0; i < 5; i++) begin
      set_voice(1, 40 + i, 20, 'h100, 0, 127);
      step();
      if (i < 4) expect_echo(100, 1, 10);
      if (i == 2) chk("full_before", full, 0);
      if (i == 3) chk("full_after4", full, 1);
      if (i == 3) chk("overflow_after4", overflow, 0);
      if (i == 4) chk("overflow_after5", overflow, 1);
    end
    run(110);
    chk("full_drained", full, 0);
    go_idle();

    // Reset with three tap-2 entries pending.
    delay = 8'd10; taps = 2'd3; decay = 2'd0;
    for (int i = 0; i < 3; i++) begin
      set_voice(1, 20 + i, 50, 'h100, 0, 127);
      step();
      expect_echo(10, 1, 25);
    end
    run(11);
    chk("pre_reset_pending", sb.size(), 0);
    set_voice(0, 0, 0, 'h100, 0, 127);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    cyc = 0;
    check_reset_state("rst2");
    run(20);

    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
